// File: rtl/mem_initiator.sv
// Data-memory initiator: turns single load/store requests into MemRead/MemWrite cycles,
// with big-endian byte/half lane handling, load extension and read-modify-write sub-word stores.
module mem_initiator #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [DEPTH+1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [DEPTH-1:0] Address,
  output logic [WIDTH-1:0] WD,
  input  logic [WIDTH-1:0] RD
);

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_RESP
  } state_t;

  state_t           state_q;
  logic             ready_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_rdata_q;
  logic             resp_err_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic [DEPTH-1:0] address_q;
  logic [WIDTH-1:0] wd_q;
  logic [1:0]       lat_q;

  // Captured request; only the low half of the store data matters after accept.
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic             unsigned_q;
  logic [15:0]      wdata_q;
  logic [WIDTH-1:0] rd_word_q;

  logic             accept_d;
  logic             req_err_d;
  logic [1:0]       byte_pos_d;
  logic             half_pos_d;
  logic [7:0]       byte_lane_d;
  logic [15:0]      half_lane_d;
  logic [WIDTH-1:0] load_ext_d;
  logic [WIDTH-1:0] merge_d;

  assign accept_d = req_valid & ready_q;

  always_comb begin
    req_err_d = 1'b0;
    unique case (req_size)
      SZ_BYTE: req_err_d = 1'b0;
      SZ_HALF: req_err_d = req_addr[0];
      SZ_WORD: req_err_d = |req_addr[1:0];
      default: req_err_d = 1'b1;
    endcase
  end

  // Big-endian: byte offset 0 lives in the most significant lane.
  assign byte_pos_d = ~off_q;
  assign half_pos_d = ~off_q[1];

  always_comb begin
    byte_lane_d = RD[{byte_pos_d, 3'b000} +: 8];
    half_lane_d = RD[{half_pos_d, 4'b0000} +: 16];
    load_ext_d  = RD;
    unique case (size_q)
      SZ_BYTE: load_ext_d = {{24{~unsigned_q & byte_lane_d[7]}}, byte_lane_d};
      SZ_HALF: load_ext_d = {{16{~unsigned_q & half_lane_d[15]}}, half_lane_d};
      default: load_ext_d = RD;
    endcase
  end

  always_comb begin
    merge_d = rd_word_q;
    if (size_q == SZ_BYTE) begin
      merge_d[{byte_pos_d, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_d[{half_pos_d, 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      wd_q         <= '0;
      lat_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      rd_word_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            ready_q    <= 1'b0;
            off_q      <= req_addr[1:0];
            size_q     <= req_size;
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            if (req_err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_write && (req_size == SZ_WORD)) begin
              state_q     <= S_WR;
              mem_write_q <= 1'b1;
              address_q   <= req_addr[DEPTH+1:2];
              wd_q        <= req_wdata;
            end else begin
              state_q    <= S_RD;
              mem_read_q <= 1'b1;
              address_q  <= req_addr[DEPTH+1:2];
              lat_q      <= '0;
            end
          end
        end
        S_RD: begin
          // RD is only trusted on the final read-enable cycle.
          if (lat_q == LAT_LAST) begin
            mem_read_q <= 1'b0;
            if (write_q) begin
              rd_word_q <= RD;
              state_q   <= S_MERGE;
            end else begin
              resp_rdata_q <= load_ext_d;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        S_MERGE: begin
          wd_q        <= merge_d;
          mem_write_q <= 1'b1;
          state_q     <= S_WR;
        end
        S_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          address_q    <= '0;
          wd_q         <= '0;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          address_q    <= '0;
          wd_q         <= '0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign Address    = address_q;
  assign WD         = wd_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: small word memory on the bus side, byte-addressed big-endian
// reference model for expected load data, store results and final memory contents.
module tb_mem_initiator;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 1;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [DEPTH+1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic             MemRead;
  logic             MemWrite;
  logic [DEPTH-1:0] Address;
  logic [WIDTH-1:0] WD;
  logic [WIDTH-1:0] RD;

  int tests_run;
  int tests_failed;

  mem_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WD(WD), .RD(RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus-side memory (16 words, registered read -> RD_LAT=1) with a backdoor port.
  logic [31:0] mem [0:15];
  logic        bd_we;
  logic [3:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (MemWrite) mem[Address[3:0]] <= WD;
    if (MemRead) RD <= mem[Address[3:0]];
  end

  // Reference: memory as a plain byte array, byte address 4*w holds the MSB.
  logic [7:0] ref_b [0:63];

  function automatic logic [31:0] model_load(input int a, input int sz, input bit uns);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v * 64'd256 + 64'(ref_b[a + i]);
    if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic void model_store(input int a, input int sz, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_b[a + i] = 8'(wd >> (8 * (n - 1 - i)));
  endfunction

  function automatic logic [31:0] model_word(input int w);
    return {ref_b[4*w], ref_b[4*w+1], ref_b[4*w+2], ref_b[4*w+3]};
  endfunction

  function automatic bit model_err(input int a, input int sz);
    if (sz == 3) return 1'b1;
    return (a % (1 << sz)) != 0;
  endfunction

  typedef struct packed {
    int          resp_c;
    int          rd_first;
    int          rd_cnt;
    int          wr_c;
    int          wr_cnt;
    int          both;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] wd_seen;
    logic [15:0] addr_seen;
    logic        ready_after;
  } obs_t;

  task automatic poke(input int w, input logic [31:0] v);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 4'(w); bd_data = v;
    @(posedge clk);
    #1 bd_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[4*w + i] = 8'(v >> (8 * (3 - i)));
  endtask

  task automatic init_mem();
    for (int w = 0; w < 16; w++) poke(w, $urandom);
  endtask

  // Issues one request and records what the bus and response do, cycle 0 = accept cycle.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [17:0] addr, input logic [31:0] wd, output obs_t o);
    int k;
    o = '0;
    o.resp_c = -1; o.rd_first = -1; o.wr_c = -1;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL ready_timeout: req_ready=%0b, required 1 within 50 cycles", req_ready);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = 18'($urandom); req_wdata = $urandom;
    for (int c = 1; c <= 20 && o.resp_c < 0; c++) begin
      @(negedge clk);
      if (MemRead && MemWrite) o.both++;
      if (MemRead) begin
        if (o.rd_first < 0) begin o.rd_first = c; o.addr_seen = Address; end
        o.rd_cnt++;
      end
      if (MemWrite) begin
        o.wr_c = c; o.wr_cnt++; o.wd_seen = WD;
        if (o.rd_first < 0) o.addr_seen = Address;
      end
      if (resp_valid) begin o.resp_c = c; o.rdata = resp_rdata; o.err = resp_err; end
    end
    @(negedge clk);
    o.ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #3;
    tests_run++;
    if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {ready,valid,err,rd,wr}=%b, required 10000",
               {req_ready, resp_valid, resp_err, MemRead, MemWrite});
    end
    tests_run++;
    if (resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got 0x%08h, required 0", resp_rdata); end
    tests_run++;
    if (Address !== 16'h0) begin tests_failed++; $display("FAIL reset_address: got 0x%04h, required 0", Address); end
    tests_run++;
    if (WD !== 32'h0) begin tests_failed++; $display("FAIL reset_wd: got 0x%08h, required 0", WD); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_reset_midop();
    int nresp, nnotready;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 18'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (MemRead !== 1'b1) begin tests_failed++; $display("FAIL midop_read_active: MemRead=%b, required 1", MemRead); end
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if ({MemRead, MemWrite, resp_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midop_async_drop: {rd,wr,valid}=%b, required 000", {MemRead, MemWrite, resp_valid});
    end
    @(negedge clk);
    rst = 1'b1;
    nresp = 0; nnotready = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) nresp++;
      if (!req_ready) nnotready++;
    end
    tests_run++;
    if (nresp !== 0) begin tests_failed++; $display("FAIL midop_no_resp: resp pulses=%0d, required 0", nresp); end
    tests_run++;
    if (nnotready !== 0) begin tests_failed++; $display("FAIL midop_ready: not-ready cycles=%0d, required 0", nnotready); end
    $display("[TB] mid-operation reset checked");
  endtask

  task automatic test_word_store_load();
    obs_t o;
    do_req(1'b1, 2'b10, 1'b0, 18'h10, 32'hDEADBEEF, o);
    $display("[TB] sw @0x0010 data=0xDEADBEEF resp_c=%0d wr_c=%0d WD=0x%08h", o.resp_c, o.wr_c, o.wd_seen);
    tests_run++;
    if (o.wr_c !== 1 || o.wr_cnt !== 1 || o.rd_cnt !== 0) begin
      tests_failed++;
      $display("FAIL sw_enables: wr_c=%0d wr_cnt=%0d rd_cnt=%0d, required 1 1 0", o.wr_c, o.wr_cnt, o.rd_cnt);
    end
    tests_run++;
    if (o.addr_seen !== 16'h0004 || o.wd_seen !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL sw_bus: Address=0x%04h WD=0x%08h, required 0x0004 0xDEADBEEF", o.addr_seen, o.wd_seen);
    end
    tests_run++;
    if (o.resp_c !== 2 || o.err !== 1'b0 || o.ready_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL sw_resp: resp_c=%0d err=%b ready_after=%b, required 2 0 1", o.resp_c, o.err, o.ready_after);
    end
    do_req(1'b0, 2'b10, 1'b0, 18'h10, 32'h0, o);
    $display("[TB] lw @0x0010 rdata=0x%08h resp_c=%0d", o.rdata, o.resp_c);
    tests_run++;
    if (o.rd_first !== 1 || o.rd_cnt !== 2 || o.wr_cnt !== 0) begin
      tests_failed++;
      $display("FAIL lw_enables: rd_first=%0d rd_cnt=%0d wr_cnt=%0d, required 1 2 0", o.rd_first, o.rd_cnt, o.wr_cnt);
    end
    tests_run++;
    if (o.resp_c !== 3 || o.rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL lw_resp: resp_c=%0d rdata=0x%08h, required 3 0xDEADBEEF", o.resp_c, o.rdata);
    end
  endtask

  task automatic test_byte_loads();
    obs_t o;
    logic [17:0] addrs [4];
    logic [1:0]  szs [4];
    bit          unss [4];
    logic [31:0] exps [4];
    addrs = '{18'h10, 18'h10, 18'h13, 18'h12};
    szs   = '{2'b00, 2'b00, 2'b00, 2'b01};
    unss  = '{1'b0, 1'b1, 1'b0, 1'b0};
    exps  = '{32'hFFFFFF80, 32'h00000080, 32'h00000034, 32'h00001234};
    poke(4, 32'h80FF1234);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, szs[i], unss[i], addrs[i], 32'hFFFFFFFF, o);
      $display("[TB] load size=%0d uns=%0b @0x%04h rdata=0x%08h resp_c=%0d", szs[i], unss[i], addrs[i], o.rdata, o.resp_c);
      tests_run++;
      if (o.rdata !== exps[i] || o.resp_c !== 3 || o.err !== 1'b0) begin
        tests_failed++;
        $display("FAIL byte_load_%0d: rdata=0x%08h resp_c=%0d err=%b, required 0x%08h 3 0",
                 i, o.rdata, o.resp_c, o.err, exps[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    obs_t o;
    poke(4, 32'h80FF1234);
    do_req(1'b1, 2'b00, 1'b0, 18'h11, 32'h123456AA, o);
    $display("[TB] sb 0xAA @0x0011 WD=0x%08h wr_c=%0d resp_c=%0d", o.wd_seen, o.wr_c, o.resp_c);
    tests_run++;
    if (o.rd_first !== 1 || o.rd_cnt !== 2 || o.wr_c !== 4 || o.wr_cnt !== 1 || o.both !== 0) begin
      tests_failed++;
      $display("FAIL sb_timing: rd_first=%0d rd_cnt=%0d wr_c=%0d wr_cnt=%0d both=%0d, required 1 2 4 1 0",
               o.rd_first, o.rd_cnt, o.wr_c, o.wr_cnt, o.both);
    end
    tests_run++;
    if (o.wd_seen !== 32'h80AA1234 || o.addr_seen !== 16'h0004) begin
      tests_failed++;
      $display("FAIL sb_merge: WD=0x%08h Address=0x%04h, required 0x80AA1234 0x0004", o.wd_seen, o.addr_seen);
    end
    tests_run++;
    if (o.resp_c !== 5 || o.rdata !== 32'h0 || o.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_resp: resp_c=%0d rdata=0x%08h err=%b, required 5 0 0", o.resp_c, o.rdata, o.err);
    end
    poke(4, 32'h80FF1234);
    do_req(1'b1, 2'b01, 1'b0, 18'h10, 32'hABCD5555, o);
    $display("[TB] sh 0x5555 @0x0010 WD=0x%08h resp_c=%0d", o.wd_seen, o.resp_c);
    tests_run++;
    if (o.wd_seen !== 32'h55551234 || o.resp_c !== 5 || o.wr_c !== 4) begin
      tests_failed++;
      $display("FAIL sh_merge: WD=0x%08h resp_c=%0d wr_c=%0d, required 0x55551234 5 4", o.wd_seen, o.resp_c, o.wr_c);
    end
  endtask

  task automatic test_errors();
    obs_t o;
    do_req(1'b0, 2'b10, 1'b0, 18'h12, 32'h0, o);
    $display("[TB] lw @0x0012 err=%b resp_c=%0d", o.err, o.resp_c);
    tests_run++;
    if (o.resp_c !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || (o.rd_cnt + o.wr_cnt) !== 0) begin
      tests_failed++;
      $display("FAIL err_misaligned: resp_c=%0d err=%b rdata=0x%08h enables=%0d, required 1 1 0 0",
               o.resp_c, o.err, o.rdata, o.rd_cnt + o.wr_cnt);
    end
    do_req(1'b1, 2'b11, 1'b0, 18'h10, 32'h12345678, o);
    $display("[TB] size=11 @0x0010 err=%b resp_c=%0d", o.err, o.resp_c);
    tests_run++;
    if (o.resp_c !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || (o.rd_cnt + o.wr_cnt) !== 0 || o.ready_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_size: resp_c=%0d err=%b rdata=0x%08h enables=%0d ready_after=%b, required 1 1 0 0 1",
               o.resp_c, o.err, o.rdata, o.rd_cnt + o.wr_cnt, o.ready_after);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] addrs [3];
    logic [1:0]  szs [3];
    bit          unss [3];
    logic [31:0] exps [3];
    int acc_c [3];
    int rsp_c [3];
    int nacc, nrsp, extra;
    addrs = '{18'h10, 18'h15, 18'h1A};
    szs   = '{2'b10, 2'b00, 2'b01};
    unss  = '{1'b0, 1'b1, 1'b0};
    poke(4, 32'h80FF1234);
    poke(5, 32'hCAFE8001);
    poke(6, 32'h0BAD9876);
    for (int i = 0; i < 3; i++) exps[i] = model_load(int'(addrs[i]), int'(szs[i]), unss[i]);
    nacc = 0; nrsp = 0; extra = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = szs[0]; req_unsigned = unss[0]; req_addr = addrs[0];
    for (int c = 0; c < 40 && nrsp < 3; c++) begin
      if (resp_valid) begin
        rsp_c[nrsp] = c;
        $display("[TB] b2b resp %0d cycle=%0d rdata=0x%08h", nrsp, c, resp_rdata);
        tests_run++;
        if (resp_rdata !== exps[nrsp]) begin
          tests_failed++;
          $display("FAIL b2b_rdata_%0d: got 0x%08h, required 0x%08h", nrsp, resp_rdata, exps[nrsp]);
        end
        nrsp++;
      end
      if (req_valid && req_ready && nacc < 3) begin
        acc_c[nacc] = c;
        nacc++;
        @(posedge clk);
        #1;
        if (nacc < 3) begin
          req_size = szs[nacc]; req_unsigned = unss[nacc]; req_addr = addrs[nacc];
        end else begin
          req_valid = 1'b0;
        end
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    repeat (6) begin
      if (resp_valid) extra++;
      @(negedge clk);
    end
    tests_run++;
    if (nacc !== 3 || nrsp !== 3 || extra !== 0) begin
      tests_failed++;
      $display("FAIL b2b_counts: accepts=%0d resps=%0d extra=%0d, required 3 3 0", nacc, nrsp, extra);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (rsp_c[i] - acc_c[i] !== 3) begin
        tests_failed++;
        $display("FAIL b2b_latency_%0d: accept->resp=%0d cycles, required 3", i, rsp_c[i] - acc_c[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (acc_c[i+1] - rsp_c[i] !== 1) begin
        tests_failed++;
        $display("FAIL b2b_spacing_%0d: resp->next accept=%0d cycles, required 1", i, acc_c[i+1] - rsp_c[i]);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    int a, sz, n, r, e_resp, e_rd, e_wr, e_wc;
    bit wr, uns, e_err;
    logic [31:0] wdata, e_rdata, e_wd;
    init_mem();
    for (int t = 0; t < 80; t++) begin
      wr = 1'($urandom);
      uns = 1'($urandom);
      r = $urandom_range(0, 7);
      sz = (r == 7) ? 3 : (r % 3);
      a = $urandom_range(0, 63);
      if (sz != 3 && $urandom_range(0, 3) != 0) begin
        n = 1 << sz;
        a = a - (a % n);
      end
      wdata = $urandom;
      e_err = model_err(a, sz);
      e_rdata = 32'h0; e_wd = 32'h0; e_rd = 0; e_wr = 0; e_wc = -1;
      if (e_err) begin
        e_resp = 1;
      end else if (!wr) begin
        e_resp = 3; e_rd = 2;
        e_rdata = model_load(a, sz, uns);
      end else begin
        model_store(a, sz, wdata);
        e_wd = model_word(a / 4);
        e_wr = 1;
        e_resp = (sz == 2) ? 2 : 5;
        e_rd = (sz == 2) ? 0 : 2;
        e_wc = (sz == 2) ? 1 : 4;
      end
      do_req(wr, 2'(sz), uns, 18'(a), wdata, o);
      $display("[TB] txn %0d wr=%0b size=%0d uns=%0b addr=0x%02h err=%0b rdata=0x%08h resp_c=%0d",
               t, wr, sz, uns, a, o.err, o.rdata, o.resp_c);
      tests_run++;
      if (o.resp_c !== e_resp || o.err !== e_err || o.rdata !== e_rdata) begin
        tests_failed++;
        $display("FAIL rand_resp_%0d: resp_c=%0d err=%b rdata=0x%08h, required %0d %b 0x%08h",
                 t, o.resp_c, o.err, o.rdata, e_resp, e_err, e_rdata);
      end
      tests_run++;
      if (o.rd_cnt !== e_rd || o.wr_cnt !== e_wr || o.wr_c !== e_wc || o.both !== 0 || o.ready_after !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_bus_%0d: rd_cnt=%0d wr_cnt=%0d wr_c=%0d both=%0d ready_after=%b, required %0d %0d %0d 0 1",
                 t, o.rd_cnt, o.wr_cnt, o.wr_c, o.both, o.ready_after, e_rd, e_wr, e_wc);
      end
      if (!e_err) begin
        tests_run++;
        if (o.addr_seen !== 16'(a / 4) || (wr && o.wd_seen !== e_wd)) begin
          tests_failed++;
          $display("FAIL rand_data_%0d: Address=0x%04h WD=0x%08h, required 0x%04h 0x%08h",
                   t, o.addr_seen, o.wd_seen, a / 4, e_wd);
        end
      end
    end
    for (int w = 0; w < 16; w++) begin
      tests_run++;
      if (mem[w] !== model_word(w)) begin
        tests_failed++;
        $display("FAIL rand_mem_%0d: memory=0x%08h, required 0x%08h", w, mem[w], model_word(w));
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    test_reset();
    init_mem();
    test_reset_midop();
    test_word_store_load();
    test_byte_loads();
    test_subword_store();
    test_errors();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
